mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: bus cycles to wait for bus_ack_i before aborting; legal range 2..255.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port if_ce_i  in  1  instruction fetch request, held until if_ready_o.
REQ-005 SHALL have port if_addr_i  in  32  fetch address.
REQ-006 SHALL have port if_data_o  out  32  fetched word, valid with if_ready_o.
REQ-007 SHALL have port if_ready_o  out  1  one-cycle fetch completion pulse.
REQ-008 SHALL have port dm_ce_i / dm_we_i  in  1 / 1  data request / write enable, held until dm_ready_o.
REQ-009 SHALL have port dm_sel_i  in  4  byte lanes.
REQ-010 SHALL have port dm_addr_i / dm_wdata_i  in  32 / 32  data address / store data.
REQ-011 SHALL have port dm_rdata_o  out  32  load data, valid with dm_ready_o.
REQ-012 SHALL have port dm_ready_o  out  1  one-cycle data completion pulse.
REQ-013 SHALL have port flush_i  in  1  pipeline flush from ctrl.
REQ-014 SHALL have port bus_cyc_o, bus_we_o  out  1 / 1  shared-bus cycle active / write.
REQ-015 SHALL have port bus_sel_o  out  4  byte lanes; bus_addr_o, bus_wdata_o  out  32 / 32.
REQ-016 SHALL have port bus_rdata_i  in  32; bus_ack_i  in  1  slave completion, one cycle.
REQ-017 SHALL have port stallreq_o  out  1  stall request to ctrl.
REQ-018 SHALL have port bus_err_o  out  1  one-cycle timeout pulse.

Function
REQ-019 SHALL implement FSM states IDLE, DATA, INST, RESP.
REQ-020 IDLE: if dm_ce_i -> DATA; else if if_ce_i -> INST; else stay. Data always wins same-cycle contention.
REQ-021 On IDLE->DATA/INST, SHALL latch addr/sel/we/wdata into bus_*_o registers and set bus_cyc_o=1 at the same edge. INST forces bus_we_o=0, bus_sel_o=4'b1111.
REQ-022 Bus outputs SHALL stay stable while bus_cyc_o=1; bus_ack_i sampled only in DATA/INST, ignored elsewhere.
REQ-023 On bus_ack_i in DATA: bus_cyc_o<=0; dm_rdata_o<=bus_rdata_i for reads, unchanged for writes; dm_ready_o<=1; -> RESP.
REQ-024 On bus_ack_i in INST: bus_cyc_o<=0; if discard flag clear, if_data_o<=bus_rdata_i and if_ready_o<=1; -> RESP.
REQ-025 RESP lasts exactly one cycle, starts no transaction, clears ready pulses on exit -> IDLE; lets requester advance before re-arbitration.
REQ-026 Minimum latency: request seen in IDLE at edge N, ack in cycle N+1, ready high in cycle N+2.
REQ-027 Wait counter (8 bit) SHALL clear on entering DATA/INST and increment each cycle without ack; at count==TIMEOUT-1 without ack: bus_cyc_o<=0, bus_err_o<=1 for one cycle, requester's ready<=1 with data 0, -> RESP.
REQ-028 Ack in the same cycle as timeout SHALL be treated as normal completion, no bus_err_o.
REQ-029 flush_i in INST (incl. ack cycle) SHALL set discard flag; bus cycle still runs to ack/timeout; no if_ready_o pulse; flag cleared in RESP.
REQ-030 flush_i SHALL NOT affect DATA transactions or abort any bus cycle.
REQ-031 stallreq_o = (dm_ce_i & ~dm_ready_o) | (if_ce_i & ~if_ready_o), combinational.
REQ-032 Requester dropping ce mid-transaction SHALL NOT abort; completion still pulses ready.

Reset
REQ-033 rst=0 at a rising edge SHALL force IDLE, all registered outputs 0 (bus_cyc_o, bus_*_o, if/dm data and ready, bus_err_o), counter 0, discard flag 0, including mid-transaction.

Verification
REQ-034 dm read 0x100 only, ack 3 cycles later with 0xDEADBEEF -> bus_cyc_o 3 cycles, dm_rdata_o=0xDEADBEEF, dm_ready_o 1 cycle, stallreq_o low in that cycle.
REQ-035 if_ce_i and dm_ce_i (write 0x55AA55AA, sel 0011) same cycle -> data write first with bus_we_o=1, bus_sel_o=0011, then RESP, then fetch; if_ready_o after dm_ready_o.
REQ-036 No ack, TIMEOUT=4 -> bus_cyc_o drops after 4 cycles, bus_err_o pulses once, if_data_o=0, if_ready_o pulses.
REQ-037 flush_i during INST, ack with 0x12345678 -> no if_ready_o, if_data_o unchanged; next fetch at new address starts after RESP.
REQ-038 rst=0 while DATA pending -> next cycle bus_cyc_o=0, all outputs 0; a late ack ignored; state IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one bus between instruction fetch and data access. Data wins contention.
// Ports: if_* fetch side, dm_* data side, bus_* shared bus, flush_i, stallreq_o.
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ready_o,
  input  logic        dm_ce_i,
  input  logic        dm_we_i,
  input  logic [3:0]  dm_sel_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_ready_o,
  input  logic        flush_i,
  output logic        bus_cyc_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        stallreq_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    INST,
    RESP
  } state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       discard;
  logic       drop;

  // A flush arriving in the ack cycle itself must still suppress delivery.
  assign drop = discard | flush_i;

  assign stallreq_o = (dm_ce_i & ~dm_ready_o)
                    | (if_ce_i & ~if_ready_o);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      discard     <= 1'b0;
      bus_cyc_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      if_data_o   <= '0;
      if_ready_o  <= 1'b0;
      dm_rdata_o  <= '0;
      dm_ready_o  <= 1'b0;
      bus_err_o   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (dm_ce_i) begin
            state       <= DATA;
            cnt         <= '0;
            bus_cyc_o   <= 1'b1;
            bus_we_o    <= dm_we_i;
            bus_sel_o   <= dm_sel_i;
            bus_addr_o  <= dm_addr_i;
            bus_wdata_o <= dm_wdata_i;
          end else if (if_ce_i) begin
            state       <= INST;
            cnt         <= '0;
            bus_cyc_o   <= 1'b1;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= 4'b1111;
            bus_addr_o  <= if_addr_i;
            bus_wdata_o <= '0;
          end
        end
        DATA: begin
          if (bus_ack_i) begin
            state      <= RESP;
            bus_cyc_o  <= 1'b0;
            dm_ready_o <= 1'b1;
            if (!bus_we_o) begin
              dm_rdata_o <= bus_rdata_i;
            end
          end else if (cnt == LAST) begin
            state      <= RESP;
            bus_cyc_o  <= 1'b0;
            bus_err_o  <= 1'b1;
            dm_ready_o <= 1'b1;
            dm_rdata_o <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        INST: begin
          if (flush_i) begin
            discard <= 1'b1;
          end
          if (bus_ack_i) begin
            state     <= RESP;
            bus_cyc_o <= 1'b0;
            if (!drop) begin
              if_data_o  <= bus_rdata_i;
              if_ready_o <= 1'b1;
            end
          end else if (cnt == LAST) begin
            state     <= RESP;
            bus_cyc_o <= 1'b0;
            bus_err_o <= 1'b1;
            if (!drop) begin
              if_data_o  <= '0;
              if_ready_o <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          // One quiet cycle so the requester can move on before re-arbitration.
          state      <= IDLE;
          discard    <= 1'b0;
          if_ready_o <= 1'b0;
          dm_ready_o <= 1'b0;
          bus_err_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests, a delay-programmable
// bus slave, and monitors that check bus requests and completion pulses.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_ce_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic [31:0] if_data_o;
  logic        if_ready_o;
  logic        dm_ce_i = 1'b0;
  logic        dm_we_i = 1'b0;
  logic [3:0]  dm_sel_i = '0;
  logic [31:0] dm_addr_i = '0;
  logic [31:0] dm_wdata_i = '0;
  logic [31:0] dm_rdata_o;
  logic        dm_ready_o;
  logic        flush_i = 1'b0;
  logic        bus_cyc_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        stallreq_o;
  logic        bus_err_o;

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk),
    .rst(rst),
    .if_ce_i(if_ce_i),
    .if_addr_i(if_addr_i),
    .if_data_o(if_data_o),
    .if_ready_o(if_ready_o),
    .dm_ce_i(dm_ce_i),
    .dm_we_i(dm_we_i),
    .dm_sel_i(dm_sel_i),
    .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o),
    .dm_ready_o(dm_ready_o),
    .flush_i(flush_i),
    .bus_cyc_o(bus_cyc_o),
    .bus_we_o(bus_we_o),
    .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i),
    .bus_ack_i(bus_ack_i),
    .stallreq_o(stallreq_o),
    .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } bus_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } resp_t;

  bus_t  bus_q[$];
  resp_t dm_q[$];
  resp_t if_q[$];

  // Bus slave: acks in the ack_delay-th cycle of a bus cycle; 0 = never.
  int          ack_delay = 0;
  logic [31:0] ack_data = '0;
  int          cyc_cnt = 0;
  logic        slave_ack = 1'b0;
  logic        inject_ack = 1'b0;

  assign bus_ack_i   = slave_ack | inject_ack;
  assign bus_rdata_i = ack_data;

  always @(negedge clk) begin
    if (bus_cyc_o && !slave_ack) begin
      cyc_cnt++;
      if (ack_delay != 0 && cyc_cnt == ack_delay) slave_ack = 1'b1;
    end else begin
      slave_ack = 1'b0;
      cyc_cnt   = 0;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a request or result.
  logic cyc_q = 1'b0;
  always @(negedge clk) begin
    bus_t  eb;
    resp_t er;
    if (bus_cyc_o && !cyc_q) begin
      if (bus_q.size() == 0) begin
        chk1("bus_unexpected", bus_cyc_o, 1'b0);
      end else begin
        eb = bus_q.pop_front();
        chk("bus_addr", bus_addr_o, eb.addr);
        chk1("bus_we", bus_we_o, eb.we);
        chk("bus_sel", 32'(bus_sel_o), 32'(eb.sel));
        if (eb.we) chk("bus_wdata", bus_wdata_o, eb.wdata);
      end
    end
    cyc_q = bus_cyc_o;
    if (dm_ready_o) begin
      if (dm_q.size() == 0) begin
        chk1("dm_ready_unexpected", dm_ready_o, 1'b0);
      end else begin
        er = dm_q.pop_front();
        chk("dm_rdata", dm_rdata_o, er.data);
        chk1("dm_err", bus_err_o, er.err);
      end
    end
    if (if_ready_o) begin
      if (if_q.size() == 0) begin
        chk1("if_ready_unexpected", if_ready_o, 1'b0);
      end else begin
        er = if_q.pop_front();
        chk("if_data", if_data_o, er.data);
        chk1("if_err", bus_err_o, er.err);
      end
    end
    if (bus_err_o && !dm_ready_o && !if_ready_o)
      chk1("bus_err_orphan", bus_err_o, 1'b0);
  end

  int   r_cyc, r_dm_t, r_if_t, r_dm_n, r_if_n, r_err_n;
  logic r_dm_stall;

  // Runs a fixed window, releasing each ce once its ready pulse is seen.
  task automatic run(input int bound);
    r_cyc = 0; r_dm_t = -1; r_if_t = -1;
    r_dm_n = 0; r_if_n = 0; r_err_n = 0; r_dm_stall = 1'b1;
    for (int t = 0; t < bound; t++) begin
      @(negedge clk);
      if (bus_cyc_o) r_cyc++;
      if (bus_err_o) r_err_n++;
      if (dm_ready_o) begin
        r_dm_n++;
        r_dm_t = t;
        r_dm_stall = stallreq_o;
        dm_ce_i = 1'b0;
      end
      if (if_ready_o) begin
        r_if_n++;
        r_if_t = t;
        if_ce_i = 1'b0;
      end
    end
  endtask

  task automatic dm_set(input logic we, input logic [3:0] sel,
                        input logic [31:0] addr, input logic [31:0] wd);
    dm_ce_i = 1'b1; dm_we_i = we; dm_sel_i = sel;
    dm_addr_i = addr; dm_wdata_i = wd;
  endtask

  task automatic check_zero(input string p);
    chk1({p, "_cyc"}, bus_cyc_o, 1'b0);
    chk1({p, "_we"}, bus_we_o, 1'b0);
    chk({p, "_sel"}, 32'(bus_sel_o), 32'd0);
    chk({p, "_addr"}, bus_addr_o, 32'd0);
    chk({p, "_wdata"}, bus_wdata_o, 32'd0);
    chk({p, "_if_data"}, if_data_o, 32'd0);
    chk1({p, "_if_ready"}, if_ready_o, 1'b0);
    chk({p, "_dm_rdata"}, dm_rdata_o, 32'd0);
    chk1({p, "_dm_ready"}, dm_ready_o, 1'b0);
    chk1({p, "_err"}, bus_err_o, 1'b0);
    chk1({p, "_stall"}, stallreq_o, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Data read, ack in the third bus cycle.
    ack_delay = 3; ack_data = 32'hDEADBEEF;
    bus_q.push_back('{32'h100, 1'b0, 4'hF, 32'h0});
    dm_q.push_back('{32'hDEADBEEF, 1'b0});
    dm_set(1'b0, 4'hF, 32'h100, 32'h0);
    run(10);
    chk("rd_cyc_len", 32'(r_cyc), 32'd3);
    chk("rd_ready_n", 32'(r_dm_n), 32'd1);
    chk1("rd_stall_in_resp", r_dm_stall, 1'b0);

    // Same-cycle contention: write first, then fetch after RESP.
    ack_delay = 2; ack_data = 32'hCAFEF00D;
    bus_q.push_back('{32'h200, 1'b1, 4'b0011, 32'h55AA55AA});
    bus_q.push_back('{32'h300, 1'b0, 4'hF, 32'h0});
    dm_q.push_back('{32'hDEADBEEF, 1'b0});
    if_q.push_back('{32'hCAFEF00D, 1'b0});
    dm_set(1'b1, 4'b0011, 32'h200, 32'h55AA55AA);
    if_ce_i = 1'b1; if_addr_i = 32'h300;
    run(16);
    chk1("contend_order", (r_dm_t >= 0) && (r_if_t > r_dm_t), 1'b1);
    chk("contend_gap", 32'(r_if_t - r_dm_t), 32'd4);
    chk("contend_if_n", 32'(r_if_n), 32'd1);

    // Fetch timeout with TIMEOUT=4.
    ack_delay = 0;
    bus_q.push_back('{32'h400, 1'b0, 4'hF, 32'h0});
    if_q.push_back('{32'h0, 1'b1});
    if_ce_i = 1'b1; if_addr_i = 32'h400;
    run(12);
    chk("to_cyc_len", 32'(r_cyc), 32'd4);
    chk("to_err_n", 32'(r_err_n), 32'd1);
    chk("to_if_n", 32'(r_if_n), 32'd1);

    // Ack coinciding with the timeout count completes normally.
    ack_delay = 4; ack_data = 32'hA5A5A5A5;
    bus_q.push_back('{32'h500, 1'b0, 4'hF, 32'h0});
    dm_q.push_back('{32'hA5A5A5A5, 1'b0});
    dm_set(1'b0, 4'hF, 32'h500, 32'h0);
    run(12);
    chk("edge_cyc_len", 32'(r_cyc), 32'd4);
    chk("edge_err_n", 32'(r_err_n), 32'd0);

    // Data timeout returns zero.
    ack_delay = 0;
    bus_q.push_back('{32'h600, 1'b0, 4'hF, 32'h0});
    dm_q.push_back('{32'h0, 1'b1});
    dm_set(1'b0, 4'hF, 32'h600, 32'h0);
    run(12);
    chk("dto_err_n", 32'(r_err_n), 32'd1);

    // Flush during fetch: result discarded, redirected fetch follows.
    ack_delay = 3; ack_data = 32'h12345678;
    bus_q.push_back('{32'h1000, 1'b0, 4'hF, 32'h0});
    bus_q.push_back('{32'h2000, 1'b0, 4'hF, 32'h0});
    @(negedge clk);
    if_ce_i = 1'b1; if_addr_i = 32'h1000;
    @(negedge clk);
    flush_i = 1'b1; if_addr_i = 32'h2000;
    @(negedge clk);
    flush_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus_cyc_o) break;
    end
    chk1("fl_resp_cyc", bus_cyc_o, 1'b0);
    chk1("fl_no_ready", if_ready_o, 1'b0);
    chk("fl_data_kept", if_data_o, 32'h0);
    ack_data = 32'h87654321;
    if_q.push_back('{32'h87654321, 1'b0});
    run(12);
    chk("fl_if_n", 32'(r_if_n), 32'd1);

    // ce dropped and flush raised mid data transaction: still completes.
    ack_delay = 3; ack_data = 32'h0BADF00D;
    bus_q.push_back('{32'h700, 1'b0, 4'hF, 32'h0});
    dm_q.push_back('{32'h0BADF00D, 1'b0});
    dm_set(1'b0, 4'hF, 32'h700, 32'h0);
    @(negedge clk);
    dm_ce_i = 1'b0; flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    run(10);
    chk("drop_dm_n", 32'(r_dm_n), 32'd1);

    // Reset while a data cycle is pending; a late ack must be ignored.
    ack_delay = 0;
    bus_q.push_back('{32'h800, 1'b0, 4'hF, 32'h0});
    dm_set(1'b0, 4'hF, 32'h800, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk1("rst_pre_cyc", bus_cyc_o, 1'b1);
    rst = 1'b0; dm_ce_i = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b1; inject_ack = 1'b1; ack_data = 32'hFFFFFFFF;
    @(negedge clk);
    inject_ack = 1'b0;
    run(4);
    chk("late_ack_cyc", 32'(r_cyc), 32'd0);
    chk("late_ack_dm_n", 32'(r_dm_n), 32'd0);

    // Normal operation resumes from IDLE.
    ack_delay = 1; ack_data = 32'h11112222;
    bus_q.push_back('{32'h900, 1'b0, 4'hF, 32'h0});
    dm_q.push_back('{32'h11112222, 1'b0});
    dm_set(1'b0, 4'hF, 32'h900, 32'h0);
    run(8);
    chk("post_cyc_len", 32'(r_cyc), 32'd1);
    chk("post_dm_n", 32'(r_dm_n), 32'd1);

    chk("bus_q_left", 32'(bus_q.size()), 32'd0);
    chk("dm_q_left", 32'(dm_q.size()), 32'd0);
    chk("if_q_left", 32'(if_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
